// File: rtl/clock_pkg.sv
// Shared types and BCD stepping helpers for the HH:MM time-of-day counter.
// No ports. This package provides:
//   mode_t    : RUN / SET_HH / SET_MM operating mode
//   bcd_digit : one 4-bit BCD digit
//   hhmm_t    : packed {h_tens, h_ones, m_tens, m_ones}, the same layout as the bcd output
//   step_minutes / step_hours : +1 on one field, wrapping 59->00 and 23->00
package clock_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2
  } mode_t;

  typedef logic [3:0] bcd_digit;

  typedef struct packed {
    bcd_digit h_tens;
    bcd_digit h_ones;
    bcd_digit m_tens;
    bcd_digit m_ones;
  } hhmm_t;

  localparam bcd_digit MIN_TENS_MAX     = 4'd5;
  localparam bcd_digit HR_TENS_MAX      = 4'd2;
  localparam bcd_digit HR_ONES_MAX_AT_2 = 4'd3;
  localparam bcd_digit DIGIT_MAX        = 4'd9;

  function automatic logic minutes_at_max(input hhmm_t t);
    return (t.m_tens == MIN_TENS_MAX) && (t.m_ones == DIGIT_MAX);
  endfunction

  function automatic logic hours_at_max(input hhmm_t t);
    return (t.h_tens == HR_TENS_MAX) && (t.h_ones == HR_ONES_MAX_AT_2);
  endfunction

  // Minutes +1 with 59 -> 00. The hours field is left untouched.
  function automatic hhmm_t step_minutes(input hhmm_t t);
    hhmm_t r;
    r = t;
    if (t.m_ones == DIGIT_MAX) begin
      r.m_ones = '0;
      r.m_tens = (t.m_tens == MIN_TENS_MAX) ? '0 : t.m_tens + 4'd1;
    end else begin
      r.m_ones = t.m_ones + 4'd1;
    end
    return r;
  endfunction

  // Hours +1 with 23 -> 00. The minutes field is left untouched.
  function automatic hhmm_t step_hours(input hhmm_t t);
    hhmm_t r;
    r = t;
    if (hours_at_max(t)) begin
      r.h_tens = '0;
      r.h_ones = '0;
    end else if (t.h_ones == DIGIT_MAX) begin
      r.h_ones = '0;
      r.h_tens = t.h_tens + 4'd1;
    end else begin
      r.h_ones = t.h_ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, ce1ms-sampled debouncer and a
// one-clk pulse on each debounced press. Releases produce no pulse.
// Ports:
//   clk     : system clock
//   rst     : asynchronous, active-high reset (debounced level = released)
//   ce1ms   : one-clk pulse per millisecond; the debouncer samples only here
//   btn_raw : raw asynchronous button level, 1 = pressed
//   press   : registered one-clk pulse on a debounced 0 -> 1 change
module btn_debounce #(
  parameter int DEB_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic ce1ms,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEB_MS + 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, exactly as the hardware does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      press  <= 1'b0;
      if (ce1ms) begin
        if (sync_q[1] == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CW'(DEB_MS - 1)) begin
          // This sample is the DEB_MS-th consecutive disagreement: accept it.
          level_q <= ~level_q;
          cnt_q   <= '0;
          press   <= ~level_q;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/clock_hhmm_counter.sv
// BCD time-of-day counter (00:00 .. 23:59) advanced by ce1min, with a
// two-button set interface and a blink flag for the field under edit.
// Ports:
//   clk      : system clock (50 MHz)
//   rst      : asynchronous, active-high reset
//   ce1min   : one-clk pulse per minute
//   ce1ms    : one-clk pulse per millisecond (debounce and blink timebase)
//   btn_mode : raw mode button, 1 = pressed (RUN -> SET_HH -> SET_MM -> RUN)
//   btn_inc  : raw increment button, 1 = pressed (steps the edited field)
//   bcd      : {h_tens, h_ones, m_tens, m_ones}
//   mode     : 0 = RUN, 1 = SET_HH, 2 = SET_MM
//   blink    : flash flag for the field under edit, 0 in RUN
//   day_co   : one-clk pulse on the 23:59 -> 00:00 wrap in RUN
module clock_hhmm_counter
  import clock_pkg::*;
#(
  parameter int DEB_MS   = 20,
  parameter int BLINK_MS = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce1min,
  input  logic        ce1ms,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [15:0] bcd,
  output logic [1:0]  mode,
  output logic        blink,
  output logic        day_co
);

  localparam int BW = $clog2(BLINK_MS + 1);

  logic          press_mode;
  logic          press_inc;
  hhmm_t         tod_q;
  hhmm_t         tod_tick;
  logic          day_end;
  logic          blink_run;
  mode_t         mode_q;
  logic [BW-1:0] blink_cnt;

  btn_debounce #(.DEB_MS(DEB_MS)) u_deb_mode (
    .clk     (clk),
    .rst     (rst),
    .ce1ms   (ce1ms),
    .btn_raw (btn_mode),
    .press   (press_mode)
  );

  btn_debounce #(.DEB_MS(DEB_MS)) u_deb_inc (
    .clk     (clk),
    .rst     (rst),
    .ce1ms   (ce1ms),
    .btn_raw (btn_inc),
    .press   (press_inc)
  );

  // Next time-of-day for a RUN minute tick, with the minute carry into hours.
  // NOTE: every signal written here gets a value on every path (defaults
  // first), otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    tod_tick = step_minutes(tod_q);
    day_end  = 1'b0;
    if (minutes_at_max(tod_q)) begin
      tod_tick = step_hours(tod_tick);
      day_end  = hours_at_max(tod_q);
    end
  end

  // The blink timebase runs only while staying in a set mode; a mode press
  // restarts or stops it instead.
  assign blink_run = ((mode_q == SET_HH) || (mode_q == SET_MM)) && !press_mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tod_q     <= '0;
      mode_q    <= RUN;
      blink     <= 1'b0;
      blink_cnt <= '0;
      day_co    <= 1'b0;
    end else begin
      day_co <= 1'b0;
      case (mode_q)
        RUN: begin
          // A minute tick and a mode press in the same clk both take effect.
          if (ce1min) begin
            tod_q  <= tod_tick;
            day_co <= day_end;
          end
          if (press_mode) begin
            mode_q    <= SET_HH;
            blink     <= 1'b1;
            blink_cnt <= '0;
          end
        end
        SET_HH: begin
          // Mode press wins over a simultaneous inc press.
          if (press_mode) begin
            mode_q    <= SET_MM;
            blink     <= 1'b1;
            blink_cnt <= '0;
          end else if (press_inc) begin
            tod_q <= step_hours(tod_q);
          end
        end
        SET_MM: begin
          if (press_mode) begin
            mode_q    <= RUN;
            blink     <= 1'b0;
            blink_cnt <= '0;
          end else if (press_inc) begin
            tod_q <= step_minutes(tod_q);
          end
        end
        default: begin
          mode_q    <= RUN;
          blink     <= 1'b0;
          blink_cnt <= '0;
        end
      endcase

      if (blink_run && ce1ms) begin
        if (blink_cnt == BW'(BLINK_MS - 1)) begin
          blink_cnt <= '0;
          blink     <= ~blink;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

  assign bcd  = tod_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_clock_hhmm_counter.sv
// Self-checking bench for clock_hhmm_counter: a behavioural model (time kept
// as integer hours/minutes, buttons as run lengths of stable ms samples) is
// compared with the DUT on every falling clk edge, and directed sequences add
// hand-computed literal expectations.
module tb_clock_hhmm_counter;

  localparam int DEB_MS   = 20;
  localparam int BLINK_MS = 500;
  localparam int MS_DIV   = 4;    // clk cycles per ce1ms tick in this bench
  localparam int HOLD_MS  = DEB_MS + 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce1min;
  logic        ce1ms;
  logic        btn_mode;
  logic        btn_inc;
  logic [15:0] bcd;
  logic [1:0]  mode;
  logic        blink;
  logic        day_co;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;
  int ms_seen  = 0;

  clock_hhmm_counter #(.DEB_MS(DEB_MS), .BLINK_MS(BLINK_MS)) dut (
    .clk      (clk),
    .rst      (rst),
    .ce1min   (ce1min),
    .ce1ms    (ce1ms),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .bcd      (bcd),
    .mode     (mode),
    .blink    (blink),
    .day_co   (day_co)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name, input int limit);
    n_checks++;
    n_errors++;
    $display("FAIL %s: no event within %0d clk (t=%0t)", name, limit, $time);
  endtask

  // ce1ms: one clk high every MS_DIV clks, driven away from the active edge.
  initial begin
    int div;
    div   = 0;
    ce1ms = 1'b0;
    forever begin
      @(negedge clk);
      ce1ms = (div == MS_DIV - 1);
      div   = (div + 1) % MS_DIV;
    end
  end

  initial forever begin
    @(posedge clk);
    if (ce1ms) ms_seen++;
  end

  // ---------------- behavioural model ----------------
  int m_hh = 0, m_mm = 0, m_mode = 0, m_bcnt = 0;
  bit m_blink = 1'b0, m_day = 1'b0;
  bit [1:0] m_sync_mode = '0, m_sync_inc = '0;
  bit m_lvl_mode = 1'b0, m_lvl_inc = 1'b0;
  int m_run_mode = 0, m_run_inc = 0;
  bit m_pend_mode = 1'b0, m_pend_inc = 1'b0;

  // A level is accepted after DEB_MS consecutive ms samples disagreeing with it.
  task automatic deb_model(input bit sample, inout bit lvl, inout int run, output bit press);
    press = 1'b0;
    if (sample == lvl) begin
      run = 0;
    end else begin
      run++;
      if (run == DEB_MS) begin
        lvl   = sample;
        run   = 0;
        press = sample;
      end
    end
  endtask

  function automatic logic [15:0] model_bcd();
    return {4'(m_hh / 10), 4'(m_hh % 10), 4'(m_mm / 10), 4'(m_mm % 10)};
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_hh = 0; m_mm = 0; m_mode = 0; m_bcnt = 0; m_blink = 1'b0; m_day = 1'b0;
      m_sync_mode = '0; m_sync_inc = '0; m_lvl_mode = 1'b0; m_lvl_inc = 1'b0;
      m_run_mode = 0; m_run_inc = 0; m_pend_mode = 1'b0; m_pend_inc = 1'b0;
    end else begin
      bit pm, pi, nm, ni, idle_set;
      int mins;
      pm = m_pend_mode;
      pi = m_pend_inc;
      nm = 1'b0;
      ni = 1'b0;
      if (ce1ms) begin
        deb_model(m_sync_mode[1], m_lvl_mode, m_run_mode, nm);
        deb_model(m_sync_inc[1], m_lvl_inc, m_run_inc, ni);
      end
      m_pend_mode = nm;
      m_pend_inc  = ni;
      m_sync_mode = {m_sync_mode[0], btn_mode};
      m_sync_inc  = {m_sync_inc[0], btn_inc};
      m_day    = 1'b0;
      idle_set = 1'b0;
      case (m_mode)
        0: begin
          if (ce1min) begin
            mins  = (m_hh * 60 + m_mm + 1) % 1440;
            m_day = (mins == 0);
            m_hh  = mins / 60;
            m_mm  = mins % 60;
          end
          if (pm) begin m_mode = 1; m_blink = 1'b1; m_bcnt = 0; end
        end
        1: begin
          if (pm) begin m_mode = 2; m_blink = 1'b1; m_bcnt = 0; end
          else begin
            if (pi) m_hh = (m_hh + 1) % 24;
            idle_set = 1'b1;
          end
        end
        2: begin
          if (pm) begin m_mode = 0; m_blink = 1'b0; m_bcnt = 0; end
          else begin
            if (pi) m_mm = (m_mm + 1) % 60;
            idle_set = 1'b1;
          end
        end
        default: m_mode = 0;
      endcase
      // blink toggles once every BLINK_MS ms ticks spent in a set mode
      if (idle_set && ce1ms) begin
        m_bcnt++;
        if (m_bcnt == BLINK_MS) begin
          m_bcnt  = 0;
          m_blink = ~m_blink;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("cyc_bcd", bcd, model_bcd());
      check("cyc_mode", mode, m_mode);
      check("cyc_blink", blink, m_blink);
      check("cyc_day_co", day_co, m_day);
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_ms(input int n);
    wait_clk(n * MS_DIV);
  endtask

  task automatic minute_pulses(input int n);
    repeat (n) begin
      ce1min = 1'b1;
      @(negedge clk);
      ce1min = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic press_mode_btn();
    btn_mode = 1'b1;
    hold_ms(HOLD_MS);
    btn_mode = 1'b0;
    hold_ms(HOLD_MS);
  endtask

  task automatic press_inc_btn();
    btn_inc = 1'b1;
    hold_ms(HOLD_MS);
    btn_inc = 1'b0;
    hold_ms(HOLD_MS);
  endtask

  task automatic wait_blink_toggle(input int limit);
    logic b0;
    int   n;
    b0 = blink;
    n  = 0;
    while (blink === b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (blink === b0) timeout_fail("blink_toggle", limit);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int guard;
    int ms0;
    rst      = 1'b1;
    ce1min   = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_bcd", bcd, 16'h0000);
    check("reset_mode", mode, 0);
    check("reset_blink", blink, 0);
    check("reset_day_co", day_co, 0);
    wait_clk(3);
    rst = 1'b0;

    // Reset in the middle of an edit at 12:34.
    minute_pulses(754);
    check("time_1234", bcd, 16'h1234);
    press_mode_btn();
    check("edit_mode", mode, 1);
    check("edit_blink", blink, 1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_bcd", bcd, 16'h0000);
    check("async_rst_mode", mode, 0);
    check("async_rst_blink", blink, 0);
    @(negedge clk);
    rst = 1'b0;
    minute_pulses(1);
    check("after_rst_0001", bcd, 16'h0001);

    // Minute and hour rollovers.
    minute_pulses(57);
    check("time_0058", bcd, 16'h0058);
    minute_pulses(1);
    check("time_0059", bcd, 16'h0059);
    minute_pulses(1);
    check("time_0100", bcd, 16'h0100);
    minute_pulses(539);
    check("time_0959", bcd, 16'h0959);
    minute_pulses(1);
    check("time_1000", bcd, 16'h1000);
    minute_pulses(59);
    check("time_1059", bcd, 16'h1059);

    // ce1min and press_mode in the same clk at 10:59.
    btn_mode = 1'b1;
    guard = 0;
    while (!m_pend_mode && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (!m_pend_mode) timeout_fail("press_mode_event", 400);
    ce1min = 1'b1;
    @(negedge clk);
    ce1min   = 1'b0;
    btn_mode = 1'b0;
    hold_ms(HOLD_MS);
    check("simul_bcd_1100", bcd, 16'h1100);
    check("simul_mode_sethh", mode, 1);

    // press_mode and press_inc together in SET_HH: mode wins.
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    hold_ms(HOLD_MS);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    hold_ms(HOLD_MS);
    check("both_mode_setmm", mode, 2);
    check("both_bcd_1100", bcd, 16'h1100);
    press_mode_btn();
    check("back_run_mode", mode, 0);
    check("back_run_blink", blink, 0);

    // Hour carry without day wrap, then the day wrap.
    minute_pulses(539);
    check("time_1959", bcd, 16'h1959);
    ce1min = 1'b1;
    @(negedge clk);
    check("time_2000", bcd, 16'h2000);
    check("no_day_co_2000", day_co, 0);
    ce1min = 1'b0;
    @(negedge clk);
    minute_pulses(239);
    check("time_2359", bcd, 16'h2359);
    ce1min = 1'b1;
    @(negedge clk);
    check("wrap_bcd_0000", bcd, 16'h0000);
    check("wrap_day_co_hi", day_co, 1);
    ce1min = 1'b0;
    @(negedge clk);
    check("wrap_day_co_lo", day_co, 0);

    // Setting the time from 22:10.
    minute_pulses(1330);
    check("time_2210", bcd, 16'h2210);
    press_mode_btn();
    check("set_hh_mode", mode, 1);
    check("set_hh_blink", blink, 1);
    minute_pulses(3);
    check("frozen_hh", bcd, 16'h2210);
    repeat (3) press_inc_btn();
    check("hours_wrap_0110", bcd, 16'h0110);
    press_mode_btn();
    check("set_mm_mode", mode, 2);
    minute_pulses(2);
    check("frozen_mm", bcd, 16'h0110);
    wait_blink_toggle(BLINK_MS * MS_DIV + 400);
    ms0 = ms_seen;
    wait_blink_toggle(BLINK_MS * MS_DIV + 400);
    check("blink_half_period_ms", ms_seen - ms0, BLINK_MS);
    repeat (50) press_inc_btn();
    check("minutes_wrap_0100", bcd, 16'h0100);
    press_mode_btn();
    check("run_again_mode", mode, 0);
    check("run_again_blink", blink, 0);

    // Bouncing mode button: toggles every 5 ms for 50 ms, then 25 ms stable.
    for (int i = 0; i < 10; i++) begin
      btn_mode = (i % 2 == 0);
      hold_ms(5);
    end
    btn_mode = 1'b1;
    hold_ms(25);
    btn_mode = 1'b0;
    hold_ms(25);
    check("bounce_one_step", mode, 1);
    // A clean 15 ms press is too short to register.
    btn_mode = 1'b1;
    hold_ms(15);
    btn_mode = 1'b0;
    hold_ms(25);
    check("short_press_ignored", mode, 1);
    press_mode_btn();
    press_mode_btn();
    check("final_mode_run", mode, 0);
    check("final_bcd", bcd, 16'h0100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
